// File: rtl/crop_pkg.sv
// Shared definitions for the crop window controller: FSM states, full-frame
// defaults and counter/compare widths.
package crop_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PEND  = 2'd2,
    APPLY = 2'd3
  } state_e;

  localparam int FULL_H_DISP = 1280;
  localparam int FULL_V_DISP = 720;
  localparam int FRAME_CNT_W = 16;
  localparam int CMP_W       = 12;

endpackage

// File: rtl/crop_cfg_check.sv
// Combinational validation of a requested crop window against the display size.
module crop_cfg_check
  import crop_pkg::*;
#(
  parameter int H_DISP = FULL_H_DISP,
  parameter int V_DISP = FULL_V_DISP,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic [X_W-1:0] start_x_i,
  input  logic [X_W-1:0] end_x_i,
  input  logic [Y_W-1:0] start_y_i,
  input  logic [Y_W-1:0] end_y_i,
  output logic           ok_o
);

  logic [CMP_W-1:0] sx, ex, sy, ey, hd, vd;

  // Bounds are compared unsigned after zero-extension to a common width.
  assign sx = CMP_W'(start_x_i);
  assign ex = CMP_W'(end_x_i);
  assign sy = CMP_W'(start_y_i);
  assign ey = CMP_W'(end_y_i);
  assign hd = CMP_W'(H_DISP);
  assign vd = CMP_W'(V_DISP);

  assign ok_o = (sx < ex) && (ex <= hd) && (sy < ey) && (ey <= vd);

endmodule

// File: rtl/crop_window_ctrl.sv
// Crop window controller: accepts window requests, validates them, and swaps the
// active window only at a frame boundary so the crop never changes mid-frame.
module crop_window_ctrl
  import crop_pkg::*;
#(
  parameter int H_DISP = FULL_H_DISP,
  parameter int V_DISP = FULL_V_DISP,
  parameter int X_W    = 11,
  parameter int Y_W    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [X_W-1:0]         cfg_start_x,
  input  logic [X_W-1:0]         cfg_end_x,
  input  logic [Y_W-1:0]         cfg_start_y,
  input  logic [Y_W-1:0]         cfg_end_y,
  input  logic                   vs_i,
  output logic [X_W-1:0]         start_x,
  output logic [X_W-1:0]         end_x,
  output logic [Y_W-1:0]         start_y,
  output logic [Y_W-1:0]         end_y,
  output logic                   cfg_applied,
  output logic                   cfg_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  state_e                 state_q;
  logic                   vs_q;
  logic                   vs_rise;
  logic                   handshake;
  logic                   win_ok;
  logic                   err_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [X_W-1:0]         sh_sx_q, sh_ex_q, sx_q, ex_q;
  logic [Y_W-1:0]         sh_sy_q, sh_ey_q, sy_q, ey_q;

  assign vs_rise   = vs_i & ~vs_q;
  assign cfg_ready = (state_q == IDLE) | ((state_q == PEND) & ~vs_rise);
  assign handshake = cfg_valid & cfg_ready;

  crop_cfg_check #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_check (
    .start_x_i (sh_sx_q),
    .end_x_i   (sh_ex_q),
    .start_y_i (sh_sy_q),
    .end_y_i   (sh_ey_q),
    .ok_o      (win_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      ex_q        <= X_W'(H_DISP);
      ey_q        <= Y_W'(V_DISP);
      sh_sx_q     <= '0;
      sh_sy_q     <= '0;
      sh_ex_q     <= '0;
      sh_ey_q     <= '0;
    end else begin
      vs_q  <= vs_i;
      err_q <= 1'b0;
      if (vs_rise) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);

      // A handshake in PEND reuses the capture path, discarding the pending window.
      if (handshake) begin
        sh_sx_q <= cfg_start_x;
        sh_ex_q <= cfg_end_x;
        sh_sy_q <= cfg_start_y;
        sh_ey_q <= cfg_end_y;
      end

      case (state_q)
        IDLE:  if (handshake) state_q <= CHECK;
        CHECK: begin
          if (win_ok) begin
            state_q <= PEND;
          end else begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        PEND: begin
          if (vs_rise) begin
            sx_q    <= sh_sx_q;
            ex_q    <= sh_ex_q;
            sy_q    <= sh_sy_q;
            ey_q    <= sh_ey_q;
            state_q <= APPLY;
          end else if (handshake) begin
            state_q <= CHECK;
          end
        end
        APPLY:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_x     = sx_q;
  assign end_x       = ex_q;
  assign start_y     = sy_q;
  assign end_y       = ey_q;
  assign cfg_applied = (state_q == APPLY);
  assign cfg_err     = err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_crop_window_ctrl.sv
// Self-checking bench for crop_window_ctrl: directed scenarios plus random traffic
// against a cycle-timestamp reference model of the window update rules.
module tb_crop_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y;
  logic        vs_i;
  logic [10:0] start_x, end_x, start_y, end_y;
  logic        cfg_applied, cfg_err;
  logic [15:0] frame_cnt;

  crop_window_ctrl #(
    .H_DISP (1280),
    .V_DISP (720),
    .X_W    (11),
    .Y_W    (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_start_x (cfg_start_x),
    .cfg_end_x   (cfg_end_x),
    .cfg_start_y (cfg_start_y),
    .cfg_end_y   (cfg_end_y),
    .vs_i        (vs_i),
    .start_x     (start_x),
    .end_x       (end_x),
    .start_y     (start_y),
    .end_y       (end_y),
    .cfg_applied (cfg_applied),
    .cfg_err     (cfg_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: windows as (sx, sy, ex, ey); events tracked by cycle number.
  int        cyc;
  int        chk_cyc, apply_cyc;
  bit        pend;
  int        sh[4], pw[4], act[4];
  bit        exp_app, exp_err;
  bit [15:0] exp_cnt;
  bit        vs_prev;
  int        app_seen, err_seen;

  function automatic bit win_ok(int w[4]);
    return (w[0] < w[2]) && (w[2] <= 1280) && (w[1] < w[3]) && (w[3] <= 720);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("window", {start_x, start_y, end_x, end_y},
        {11'(act[0]), 11'(act[1]), 11'(act[2]), 11'(act[3])});
    chk("cfg_applied", cfg_applied, exp_app);
    chk("cfg_err", cfg_err, exp_err);
    chk("frame_cnt", frame_cnt, exp_cnt);
    app_seen += int'(cfg_applied);
    err_seen += int'(cfg_err);
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; vs_i = 1'b0;
    cfg_start_x = '0; cfg_end_x = '0; cfg_start_y = '0; cfg_end_y = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    act = '{0, 0, 1280, 720};
    pend = 0; chk_cyc = -100; apply_cyc = -100;
    exp_app = 0; exp_err = 0; exp_cnt = '0; vs_prev = 0; cyc = 0;
    check_outputs();
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic cycle(input bit v, input bit vs, input int sx, input int sy,
                       input int ex, input int ey, output bit acc);
    bit rise, rdy;
    cfg_valid = v; vs_i = vs;
    cfg_start_x = 11'(sx); cfg_start_y = 11'(sy);
    cfg_end_x = 11'(ex); cfg_end_y = 11'(ey);
    #2;
    rise = vs && !vs_prev;
    rdy  = (cyc != chk_cyc + 1) && (cyc != apply_cyc) && !(pend && rise);
    chk("cfg_ready", cfg_ready, rdy);
    exp_err = 0;
    exp_app = 0;
    if (cyc == chk_cyc + 1) begin
      if (win_ok(sh)) begin pend = 1; pw = sh; end
      else exp_err = 1;
    end else if (pend && rise) begin
      act = pw; pend = 0; exp_app = 1; apply_cyc = cyc + 1;
    end
    acc = rdy && v;
    if (acc) begin
      sh = '{sx, sy, ex, ey}; chk_cyc = cyc; pend = 0;
    end
    if (rise) exp_cnt++;
    vs_prev = vs;
    @(posedge clk); #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit vs);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, vs, 0, 0, 0, 0, a);
  endtask

  task automatic offer(input int sx, input int sy, input int ex, input int ey);
    bit a;
    cycle(1, 0, sx, sy, ex, ey, a);
    chk("offer_accepted", a, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int base_app, base_err;

    do_reset();
    idle(2, 0);

    // Valid offer, frame boundary 20 cycles later.
    base_app = app_seen; base_err = err_seen;
    offer(100, 50, 740, 530);
    idle(20, 0);
    idle(3, 1);
    idle(2, 0);
    chk("valid_applied_once", app_seen - base_app, 1);
    chk("valid_no_err", err_seen - base_err, 0);
    chk("valid_window", {start_x, start_y, end_x, end_y}, {11'd100, 11'd50, 11'd740, 11'd530});

    // Invalid offers: empty x range, and y beyond frame height.
    base_err = err_seen;
    offer(800, 0, 800, 720);
    idle(4, 0);
    offer(0, 0, 1280, 721);
    idle(4, 0);
    chk("invalid_err_pulses", err_seen - base_err, 2);

    // Latest wins.
    base_app = app_seen; base_err = err_seen;
    offer(10, 20, 30, 40);
    idle(4, 0);
    offer(200, 100, 1280, 720);
    idle(4, 0);
    idle(2, 1);
    idle(2, 0);
    chk("latest_applied_once", app_seen - base_app, 1);
    chk("latest_no_err", err_seen - base_err, 0);
    chk("latest_window", {start_x, start_y, end_x, end_y}, {11'd200, 11'd100, 11'd1280, 11'd720});

    // Offer coinciding with a frame boundary in PEND is held until after APPLY.
    offer(0, 0, 640, 360);
    idle(3, 0);
    a = 0;
    for (int k = 0; k < 10 && !a; k++) cycle(1, 1, 5, 6, 7, 8, a);
    chk("coincide_held_accepted", a, 1'b1);
    chk("coincide_window", {start_x, start_y, end_x, end_y}, {11'd0, 11'd0, 11'd640, 11'd360});
    idle(3, 0);
    idle(2, 1);
    idle(2, 0);
    chk("coincide_second_window", {start_x, start_y, end_x, end_y}, {11'd5, 11'd6, 11'd7, 11'd8});

    // Reset while a window is pending discards it.
    offer(300, 300, 400, 400);
    idle(4, 0);
    base_app = app_seen;
    do_reset();
    idle(2, 1);
    idle(2, 0);
    chk("reset_pend_no_apply", app_seen - base_app, 0);

    // Counter wrap, preloaded near the top of its range.
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      idle(1, 1);
      idle(1, 0);
    end
    chk("frame_cnt_wrapped", frame_cnt, 16'h0001);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      int sx, sy, ex, ey;
      bit v, vs;
      if ($urandom_range(0, 1) == 0) begin
        sx = $urandom_range(0, 1279); ex = $urandom_range(sx + 1, 1280);
        sy = $urandom_range(0, 719);  ey = $urandom_range(sy + 1, 720);
      end else begin
        sx = $urandom_range(0, 2047); ex = $urandom_range(0, 2047);
        sy = $urandom_range(0, 2047); ey = $urandom_range(0, 2047);
      end
      v  = ($urandom_range(0, 3) == 0);
      vs = ($urandom_range(0, 5) == 0) ? !vs_prev : vs_prev;
      cycle(v, vs, sx, sy, ex, ey, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crop_window_ctrl.md
CROP_WINDOW_CTRL -- requirements
Module: crop_window_ctrl

Interface
REQ-001 SHALL have parameter H_DISP, default 1280: active line width in pixels.
REQ-002 SHALL have parameter V_DISP, default 720: active frame height in lines.
REQ-003 SHALL have parameter X_W, default 11: width of all x coordinates.
REQ-004 SHALL have parameter Y_W, default 11: width of all y coordinates.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_valid  input  1  new crop window offered.
REQ-008 SHALL have port cfg_ready  output  1  window accepted when cfg_valid and cfg_ready are both high.
REQ-009 SHALL have ports cfg_start_x / cfg_end_x  input  X_W  requested x bounds, half-open [start, end).
REQ-010 SHALL have ports cfg_start_y / cfg_end_y  input  Y_W  requested y bounds, half-open [start, end).
REQ-011 SHALL have port vs_i  input  1  frame sync, level-high, in the clk domain.
REQ-012 SHALL have ports start_x / end_x  output  X_W  active window x bounds, driving the crop datapath.
REQ-013 SHALL have ports start_y / end_y  output  Y_W  active window y bounds, driving the crop datapath.
REQ-014 SHALL have port cfg_applied  output  1  one-cycle pulse when a new window takes effect.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse when an offered window is rejected.
REQ-016 SHALL have port frame_cnt  output  16  count of vs_i rising edges.

Function
REQ-017 SHALL detect a frame boundary (vs_rise) as vs_i high while a one-cycle-delayed register of vs_i is low.
REQ-018 SHALL implement the states IDLE, CHECK, PEND and APPLY.
REQ-019 SHALL drive cfg_ready = (state==IDLE) | (state==PEND & ~vs_rise).
REQ-020 SHALL, on a handshake, capture all four cfg_* values into a shadow register set and move to CHECK.
REQ-021 SHALL, in CHECK (exactly one cycle), treat the shadow window as valid iff start_x < end_x <= H_DISP and start_y < end_y <= V_DISP, compared unsigned and zero-extended to 12 bits.
REQ-022 SHALL, on a valid CHECK, move to PEND.
REQ-023 SHALL, on an invalid CHECK, move to IDLE and pulse cfg_err in the following cycle; active outputs stay unchanged.
REQ-024 SHALL, in PEND with vs_rise, load the shadow window into the active outputs on that clock edge and move to APPLY.
REQ-025 SHALL make the new outputs visible in the APPLY cycle, with cfg_applied = (state==APPLY).
REQ-026 SHALL move from APPLY to IDLE unconditionally.
REQ-027 SHALL, on a handshake while in PEND, overwrite the shadow window (latest wins) and move to CHECK; the earlier pending window is discarded without cfg_err.
REQ-028 SHALL, when vs_rise and cfg_valid coincide in PEND, apply the pending window; the new offer is not accepted because cfg_ready is low.
REQ-029 SHALL ignore a vs_rise occurring in CHECK or APPLY for apply purposes; a valid window then waits for the next vs_rise.
REQ-030 SHALL never change the active outputs except on the PEND-to-APPLY edge or on reset, so the crop window never changes mid-frame.
REQ-031 SHALL increment frame_cnt on every vs_rise in any state, wrapping from 0xFFFF to 0.
REQ-032 SHALL have latency: handshake at cycle T -> CHECK at T+1 -> PEND at T+2, or cfg_err high at T+2.

Reset
REQ-033 SHALL, on rst high at a clk edge, set state=IDLE, start_x=0, start_y=0, end_x=H_DISP, end_y=V_DISP (full frame), frame_cnt=0, cfg_applied=0, cfg_err=0, and clear the vs_i delay register.
REQ-034 SHALL, on reset mid-operation, discard any shadow or pending window; the full-frame window is active from the first cycle after reset.

Structure
REQ-035 SHALL place the state encoding, the full-frame default constants and the frame_cnt width in the shared package crop_pkg.
REQ-036 SHALL implement the window validation as the combinational sub-module crop_cfg_check (inputs: shadow window, H_DISP, V_DISP; output: ok).

Verification
REQ-037 SHALL cover reset: after rst, outputs 0/0/1280/720 and cfg_ready=1.
REQ-038 SHALL cover a valid offer: offer (100,50,740,530), then a vs_rise 20 cycles later -> outputs hold their old values until the edge, cfg_applied high for exactly one cycle, then outputs (100,50,740,530).
REQ-039 SHALL cover invalid offers: start_x=800 with end_x=800, or end_y=721 -> cfg_err pulse at T+2, outputs unchanged, state IDLE.
REQ-040 SHALL cover latest-wins: offer A, then offer B while in PEND, then vs_rise -> only B applied, one cfg_applied pulse, no cfg_err.
REQ-041 SHALL cover coincidence: cfg_valid and vs_rise in the same PEND cycle -> cfg_ready=0, pending window applied, the held offer accepted in the IDLE cycle after APPLY.
REQ-042 SHALL cover reset and wrap: rst asserted while in PEND -> full-frame outputs and no cfg_applied; 65536 vs_rise events -> frame_cnt wraps to 0.
